// File: rtl/sqrt_lut_rom.sv
// Synchronous read-only table of floor(sqrt(a * 2**DATA_WIDTH)), i.e. sqrt(a) with DATA_WIDTH/2 fraction bits.
// Contents are fixed at elaboration. There is an optional second output register.
module sqrt_lut_rom #(
    parameter int    ADDR_WIDTH = 8,
    parameter int    DATA_WIDTH = 8,
    parameter int    OUTPUT_REG = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int              DEPTH    = 2 ** ADDR_WIDTH;
    localparam longint unsigned MAX_WORD = (64'd1 << DATA_WIDTH) - 64'd1;

    // Integer sqrt, one result bit at a time from the MSB, so elaboration stays cheap.
    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned root;
        longint unsigned cand;
        root = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            cand = root | (64'd1 << b);
            if (cand * cand <= v) begin
                root = cand;
            end
        end
        return root;
    endfunction

    function automatic logic [DEPTH*DATA_WIDTH-1:0] build_table();
        logic [DEPTH*DATA_WIDTH-1:0] t;
        longint unsigned             root;
        t = '0;
        for (int a = 0; a < DEPTH; a++) begin
            root = isqrt(64'(a) << DATA_WIDTH);
            if (root > MAX_WORD) begin
                root = MAX_WORD;
            end
            t[a*DATA_WIDTH +: DATA_WIDTH] = root[DATA_WIDTH-1:0];
        end
        return t;
    endfunction

    logic [DATA_WIDTH-1:0] rom_word;
    logic [DATA_WIDTH-1:0] pipe_word;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    localparam logic [DEPTH*DATA_WIDTH-1:0] TABLE = build_table();
    assign rom_word = TABLE[int'(addr)*DATA_WIDTH +: DATA_WIDTH];

    generate
        if (OUTPUT_REG != 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] stage1_d;
            logic [DATA_WIDTH-1:0] stage1_q;

            always_comb begin
                stage1_d = rom_word;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage1_q <= '0;
                end else begin
                    stage1_q <= stage1_d;
                end
            end

            assign pipe_word = stage1_q;
        end else begin : g_direct
            assign pipe_word = rom_word;
        end
    endgenerate

    always_comb begin
        rd_data_d = pipe_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sqrt_lut_rom.sv
// Directed bench for sqrt_lut_rom: one instance with 1-cycle latency and one with 2-cycle latency.
// Both instances share the same clock, reset and address.
module tb_sqrt_lut_rom;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] rd_data0;
    logic [7:0] rd_data1;

    int checks;
    int errors;

    sqrt_lut_rom #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .OUTPUT_REG(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_data(rd_data0)
    );

    sqrt_lut_rom #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .OUTPUT_REG(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_data(rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference square root by linear search, clamped to the 8-bit output range.
    function automatic int ref_sqrt(input int a);
        int v;
        int r;
        v = a * 256;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        addr  = 8'd255;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (rd_data0 !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold0 cycle %0d got %0d expected 0", i, rd_data0);
            end
            checks++;
            if (rd_data1 !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold1 cycle %0d got %0d expected 0", i, rd_data1);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rd_data0 !== 8'd255) begin
            errors++;
            $display("[TB] FAIL reset_release0 got %0d expected 255", rd_data0);
        end
        checks++;
        if (rd_data1 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_release1_first got %0d expected 0", rd_data1);
        end
        tick();
        checks++;
        if (rd_data1 !== 8'd255) begin
            errors++;
            $display("[TB] FAIL reset_release1_second got %0d expected 255", rd_data1);
        end
    endtask

    task automatic test_sweep();
        int spot_addr [8] = '{0, 1, 2, 3, 4, 64, 100, 255};
        int spot_val  [8] = '{0, 16, 22, 27, 32, 128, 160, 255};
        int prev;
        prev = 0;
        for (int n = 0; n < 256; n++) begin
            addr = 8'(n);
            tick();
            checks++;
            if (rd_data0 !== 8'(ref_sqrt(n))) begin
                errors++;
                $display("[TB] FAIL sweep addr %0d got %0d expected %0d", n, rd_data0, ref_sqrt(n));
            end
            if (n > 0) begin
                checks++;
                if (int'(rd_data0) < prev) begin
                    errors++;
                    $display("[TB] FAIL monotonic addr %0d got %0d expected >= %0d", n, rd_data0, prev);
                end
                checks++;
                if (rd_data1 !== 8'(ref_sqrt(n - 1))) begin
                    errors++;
                    $display("[TB] FAIL sweep_pipe addr %0d got %0d expected %0d", n - 1, rd_data1, ref_sqrt(n - 1));
                end
            end
            for (int s = 0; s < 8; s++) begin
                if (spot_addr[s] == n) begin
                    checks++;
                    if (rd_data0 !== 8'(spot_val[s])) begin
                        errors++;
                        $display("[TB] FAIL spot addr %0d got %0d expected %0d", n, rd_data0, spot_val[s]);
                    end
                end
            end
            prev = int'(rd_data0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6] = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
        for (int i = 0; i < 6; i++) begin
            addr = seq[i];
            tick();
            checks++;
            if (rd_data0 !== seq[i]) begin
                errors++;
                $display("[TB] FAIL alternate step %0d got %0d expected %0d", i, rd_data0, seq[i]);
            end
            if (i > 0) begin
                checks++;
                if (rd_data1 !== seq[i-1]) begin
                    errors++;
                    $display("[TB] FAIL alternate_pipe step %0d got %0d expected %0d", i, rd_data1, seq[i-1]);
                end
            end
        end
    endtask

    task automatic test_output_reg();
        addr = 8'd4;
        tick();
        addr = 8'd100;
        tick();
        checks++;
        if (rd_data1 !== 8'd32) begin
            errors++;
            $display("[TB] FAIL pipe_addr4 got %0d expected 32", rd_data1);
        end
        tick();
        checks++;
        if (rd_data1 !== 8'd160) begin
            errors++;
            $display("[TB] FAIL pipe_addr100 got %0d expected 160", rd_data1);
        end
        tick();
        checks++;
        if (rd_data1 !== 8'd160) begin
            errors++;
            $display("[TB] FAIL pipe_hold got %0d expected 160", rd_data1);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (rd_data1 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL pipe_reset got %0d expected 0", rd_data1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rd_data1 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL pipe_stage1_cleared got %0d expected 0", rd_data1);
        end
        checks++;
        if (rd_data0 !== 8'd160) begin
            errors++;
            $display("[TB] FAIL pipe_direct_recover got %0d expected 160", rd_data0);
        end
        tick();
        checks++;
        if (rd_data1 !== 8'd160) begin
            errors++;
            $display("[TB] FAIL pipe_recover got %0d expected 160", rd_data1);
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 60; n < 64; n++) begin
            addr = 8'(n);
            tick();
            checks++;
            if (rd_data0 !== 8'(ref_sqrt(n))) begin
                errors++;
                $display("[TB] FAIL midreset_pre addr %0d got %0d expected %0d", n, rd_data0, ref_sqrt(n));
            end
        end
        addr  = 8'd64;
        rst_n = 1'b0;
        tick();
        checks++;
        if (rd_data0 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear got %0d expected 0", rd_data0);
        end
        rst_n = 1'b1;
        for (int n = 65; n < 70; n++) begin
            addr = 8'(n);
            tick();
            checks++;
            if (rd_data0 !== 8'(ref_sqrt(n))) begin
                errors++;
                $display("[TB] FAIL midreset_resume addr %0d got %0d expected %0d", n, rd_data0, ref_sqrt(n));
            end
        end
        checks++;
        if (ref_sqrt(65) != 128) begin
            errors++;
            $display("[TB] FAIL model_addr65 got %0d expected 128", ref_sqrt(65));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        addr   = 8'd0;
        $display("[TB] start");
        test_reset();
        test_sweep();
        test_back_to_back();
        test_output_reg();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
